gshare_predictor: RTL

//  Gshare direction predictor for the IF stage. It hashes the fetch PC with a

---
 rtl/gshare_if.sv | 41 ++++
 rtl/gshare_predictor.sv | 110 +++++++++++
 2 files changed

// File: rtl/gshare_if.sv
// Bundle of the IF-side prediction request/response, the EX-side
// resolution bus and the perf counters of the gshare predictor.
interface gshare_if #(
   parameter int S_INDEX  = 7,
   parameter int HIST_LEN = 7
);
   // IF request and combinational response
   logic                pred_valid;
   logic                stall;
   logic [31:0]         pred_pc;
   logic                pred_taken;
   logic [S_INDEX-1:0]  pred_idx;
   logic [HIST_LEN-1:0] pred_ghr;

   // EX resolution
   logic                res_valid;
   logic [S_INDEX-1:0]  res_idx;
   logic [HIST_LEN-1:0] res_ghr;
   logic                res_taken;
   logic                res_mispredict;

   // Perf statistics
   logic [31:0]         cnt_resolved;
   logic [31:0]         cnt_mispred;

   // Pipeline side: issues requests and resolutions, reads predictions
   modport master (
      output pred_valid, stall, pred_pc,
      output res_valid, res_idx, res_ghr, res_taken, res_mispredict,
      input  pred_taken, pred_idx, pred_ghr,
      input  cnt_resolved, cnt_mispred
   );

   // Predictor side
   modport slave (
      input  pred_valid, stall, pred_pc,
      input  res_valid, res_idx, res_ghr, res_taken, res_mispredict,
      output pred_taken, pred_idx, pred_ghr,
      output cnt_resolved, cnt_mispred
   );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor speculative global history indexes a
// table of 2-bit saturating counters. Zero-cycle prediction with
// write-through bypass from a same-cycle resolution, GHR repair on
// mispredict, and saturating resolve/mispredict statistics.
module gshare_predictor #(
   parameter int S_INDEX  = 7,
   parameter int HIST_LEN = 7,
   parameter int PC_LSB   = 2
) (
   input  logic     clk,
   input  logic     rst,
   gshare_if.slave  bus
);

   localparam int ENTRIES = 1 << S_INDEX;

   typedef logic [1:0] ctr_t;

   // Saturating 2-bit counter step towards the resolved direction
   function automatic ctr_t ctr_train(input ctr_t c, input logic taken);
      ctr_t r;
      if (taken) r = (c == 2'b11) ? c : c + 2'd1;
      else       r = (c == 2'b00) ? c : c - 2'd1;
      return r;
   endfunction

   // 32-bit event counter that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Shift a direction bit into the history; for HIST_LEN==1 this reduces
   // to replacing the single history bit with the new direction
   function automatic logic [HIST_LEN-1:0] hist_push(input logic [HIST_LEN-1:0] h,
                                                     input logic               b);
      return HIST_LEN'({h, b});
   endfunction

   ctr_t                r_pht [ENTRIES];
   logic [HIST_LEN-1:0] r_ghr;
   logic [31:0]         r_cnt_resolved;
   logic [31:0]         r_cnt_mispred;

   logic [S_INDEX-1:0]  w_idx;
   ctr_t                w_ctr_rd;
   ctr_t                w_ctr_upd;
   logic                w_bypass;
   logic                w_pred_taken;
   logic                w_repair;
   logic                w_spec_shift;

   // Index hash: the history is zero-extended into the low index bits
   assign w_idx = bus.pred_pc[PC_LSB +: S_INDEX] ^ S_INDEX'(r_ghr);

   assign w_ctr_rd  = r_pht[w_idx];
   assign w_ctr_upd = ctr_train(r_pht[bus.res_idx], bus.res_taken);

   // A resolution writing the entry being read this cycle is forwarded so
   // the prediction matches what the table will hold after the edge
   assign w_bypass     = bus.res_valid && (bus.res_idx == w_idx);
   assign w_pred_taken = w_bypass ? w_ctr_upd[1] : w_ctr_rd[1];

   // Mispredict repair wins over the speculative shift of a new fetch
   assign w_repair     = bus.res_valid && bus.res_mispredict;
   assign w_spec_shift = bus.pred_valid && !bus.stall;

   assign bus.pred_idx     = w_idx;
   assign bus.pred_ghr     = r_ghr;
   assign bus.pred_taken   = w_pred_taken;
   assign bus.cnt_resolved = r_cnt_resolved;
   assign bus.cnt_mispred  = r_cnt_mispred;

   // Pattern history table: reset to weakly not-taken, trained on resolve
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_pht[i] <= 2'b01;
         end
      end else if (bus.res_valid) begin
         r_pht[bus.res_idx] <= w_ctr_upd;
      end
   end

   // Global history: repair from the checkpoint, else speculative shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ghr <= '0;
      end else if (w_repair) begin
         r_ghr <= hist_push(bus.res_ghr, bus.res_taken);
      end else if (w_spec_shift) begin
         r_ghr <= hist_push(r_ghr, w_pred_taken);
      end
   end

   // Resolve / mispredict statistics, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt_resolved <= '0;
         r_cnt_mispred  <= '0;
      end else begin
         if (bus.res_valid) begin
            r_cnt_resolved <= sat_inc32(r_cnt_resolved);
         end
         if (w_repair) begin
            r_cnt_mispred <= sat_inc32(r_cnt_mispred);
         end
      end
   end

endmodule
